// File: rtl/gpo_core_fifo_addr.sv
// -----------------------------------------------------------------------------
// gpo_core_fifo_addr
//
// GPO channel core. 128-bit command words whose address field matches
// DEST_VAL are compacted to 64 bits ({header, data}), queued in a FIFO and
// issued to one output device over a valid/ready handshake. An override mode
// forces override_value onto the output without disturbing the queue, and
// dropped words are reported with an error code and the offending word.
//
// Optional feature macro: GPO_ERROR_COUNT_EN
//   defined   : error_count is a 16-bit saturating count of error events
//   undefined : error_count is tied to zero
//
// Parameters
//   DEST_VAL       channel address this core responds to
//   CHANNEL_LENGTH address width taken from gpo_in[96 +: CHANNEL_LENGTH] (1..32)
//   FIFO_DEPTH     queue entries, power of two (2..64)
//
// Ports
//   CLK100MHZ       system clock, rising edge
//   resetn          asynchronous active-low reset
//   counter_matched timestamp compare hit for gpo_in this cycle
//   gpo_in          command word: [127:96] header/address, [31:0] data
//   override_en     level: present override_value instead of queued words
//   override_value  override payload
//   gpo_out_ready   downstream accepts the current word
//   gpo_out_valid   gpo_out holds a word to issue (registered)
//   gpo_out         issued word (registered)
//   selected        one-cycle pulse after each accepted issue
//   fifo_level      words waiting in the queue (output stage excluded)
//   error_valid     one-cycle pulse on an error
//   error_code      01 overflow, 10 override conflict; held until next error
//   error_data      offending command word; held until next error
//   error_count     saturating error counter (see macro above)
// -----------------------------------------------------------------------------
module gpo_core_fifo_addr #(
  parameter logic [14:0] DEST_VAL       = 15'h0,
  parameter int          CHANNEL_LENGTH = 12,
  parameter int          FIFO_DEPTH     = 4
) (
  input  logic                          CLK100MHZ,
  input  logic                          resetn,
  input  logic                          counter_matched,
  input  logic [127:0]                  gpo_in,
  input  logic                          override_en,
  input  logic [63:0]                   override_value,
  input  logic                          gpo_out_ready,
  output logic                          gpo_out_valid,
  output logic [63:0]                   gpo_out,
  output logic                          selected,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          error_valid,
  output logic [1:0]                    error_code,
  output logic [127:0]                  error_data,
  output logic [15:0]                   error_count
);

  localparam int              AW       = $clog2(FIFO_DEPTH);
  localparam int              CW       = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [31:0]     DEST_EXT = 32'(DEST_VAL);

  localparam logic [1:0]      ERR_OVERFLOW = 2'b01;
  localparam logic [1:0]      ERR_CONFLICT = 2'b10;

  // Output stage: ST_FULL means stage_word holds a queued word not yet issued.
  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t        state, state_nxt;
  logic [63:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [63:0]   stage_word, stage_word_nxt;
  logic          ovr_q;

  logic match, fifo_empty, fifo_full;
  logic stage_acc, pop, push, overflow, conflict, err_evt;

  assign match      = counter_matched &
                      (gpo_in[96 +: CHANNEL_LENGTH] == DEST_EXT[CHANNEL_LENGTH-1:0]);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  assign fifo_level = count;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    stage_word_nxt = stage_word;

    // The stage word is only being accepted when it, not the override
    // payload, is what the downstream currently sees.
    stage_acc = (state == ST_FULL) & ~ovr_q & gpo_out_ready;

    // No pops while override is asserted: the queue is frozen.
    pop  = ((state == ST_EMPTY) | stage_acc) & ~fifo_empty & ~override_en;
    // A full queue can still take a word when a pop frees a slot this edge.
    push     = match & ~override_en & (~fifo_full | pop);
    overflow = match & ~override_en & fifo_full & ~pop;
    conflict = match & override_en;
    err_evt  = overflow | conflict;

    if (pop) begin
      state_nxt      = ST_FULL;
      stage_word_nxt = mem[rd_ptr];
    end else if (stage_acc) begin
      state_nxt      = ST_EMPTY;
    end
  end

  // NOTE: the queue storage has no reset; its content is meaningless until
  // written, and the pointers/count (which are reset) decide what is valid.
  always_ff @(posedge CLK100MHZ) begin
    if (push) mem[wr_ptr] <= {gpo_in[127:96], gpo_in[31:0]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_EMPTY;
      stage_word    <= '0;
      ovr_q         <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      gpo_out_valid <= 1'b0;
      gpo_out       <= '0;
      selected      <= 1'b0;
      error_valid   <= 1'b0;
      error_code    <= '0;
      error_data    <= '0;
    end else begin
      state      <= state_nxt;
      stage_word <= stage_word_nxt;
      ovr_q      <= override_en;

      // Outputs are registered; override takes the output with one cycle of
      // latency and the retained stage word comes back once it drops.
      gpo_out_valid <= override_en | (state_nxt == ST_FULL);
      gpo_out       <= override_en ? override_value : stage_word_nxt;
      selected      <= gpo_out_valid & gpo_out_ready;

      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      error_valid <= err_evt;
      if (err_evt) begin
        error_code <= conflict ? ERR_CONFLICT : ERR_OVERFLOW;
        error_data <= gpo_in;
      end
    end
  end

`ifdef GPO_ERROR_COUNT_EN
  logic [15:0] err_cnt;

  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      err_cnt <= '0;
    end else if (err_evt && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

  assign error_count = err_cnt;
`else
  assign error_count = '0;
`endif

endmodule

// File: tb/tb_gpo_core_fifo_addr.sv
// -----------------------------------------------------------------------------
// tb_gpo_core_fifo_addr
//
// Directed bench for gpo_core_fifo_addr with default parameters
// (DEST_VAL=0, CHANNEL_LENGTH=12, FIFO_DEPTH=4). A vector table covers the
// single-word path, address filtering and handshake stalls; hand-written
// sequences cover overflow, override/return-to-queue, async reset and the
// error counter.
// -----------------------------------------------------------------------------
module tb_gpo_core_fifo_addr;

  logic          clk = 1'b0;
  logic          resetn;
  logic          counter_matched;
  logic [127:0]  gpo_in;
  logic          override_en;
  logic [63:0]   override_value;
  logic          gpo_out_ready;
  logic          gpo_out_valid;
  logic [63:0]   gpo_out;
  logic          selected;
  logic [2:0]    fifo_level;
  logic          error_valid;
  logic [1:0]    error_code;
  logic [127:0]  error_data;
  logic [15:0]   error_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  gpo_core_fifo_addr dut (
    .CLK100MHZ       (clk),
    .resetn          (resetn),
    .counter_matched (counter_matched),
    .gpo_in          (gpo_in),
    .override_en     (override_en),
    .override_value  (override_value),
    .gpo_out_ready   (gpo_out_ready),
    .gpo_out_valid   (gpo_out_valid),
    .gpo_out         (gpo_out),
    .selected        (selected),
    .fifo_level      (fifo_level),
    .error_valid     (error_valid),
    .error_code      (error_code),
    .error_data      (error_data),
    .error_count     (error_count)
  );

  typedef struct {
    logic        cm;
    logic [31:0] hdr;
    logic [31:0] dat;
    logic        ovr;
    logic [63:0] oval;
    logic        rdy;
    logic        e_valid;
    logic [63:0] e_out;
    logic [2:0]  e_level;
    logic        e_sel;
    logic        e_err;
  } vec_t;

  localparam logic [63:0] OVR_VAL = 64'hDEAD_BEEF_0000_0001;

  // Middle bits are non-zero so the compaction to {header, data} is visible.
  function automatic logic [127:0] mk(input logic [31:0] hdr, input logic [31:0] dat);
    return {hdr, 64'h0123_4567_89AB_CDEF, dat};
  endfunction

  function automatic vec_t v(input logic cm, input logic [31:0] hdr, input logic [31:0] dat,
                             input logic ovr, input logic rdy, input logic e_valid,
                             input logic [63:0] e_out, input logic [2:0] e_level,
                             input logic e_sel, input logic e_err);
    vec_t r;
    r.cm = cm; r.hdr = hdr; r.dat = dat; r.ovr = ovr; r.oval = OVR_VAL; r.rdy = rdy;
    r.e_valid = e_valid; r.e_out = e_out; r.e_level = e_level;
    r.e_sel = e_sel; r.e_err = e_err;
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, clock once, compare the registered outputs.
  task automatic apply(input string tag, input vec_t x);
    counter_matched = x.cm;
    gpo_in          = mk(x.hdr, x.dat);
    override_en     = x.ovr;
    override_value  = x.oval;
    gpo_out_ready   = x.rdy;
    tick();
    check({tag, ".valid"}, 128'(gpo_out_valid), 128'(x.e_valid));
    if (x.e_valid) check({tag, ".out"}, 128'(gpo_out), 128'(x.e_out));
    check({tag, ".level"}, 128'(fifo_level), 128'(x.e_level));
    check({tag, ".selected"}, 128'(selected), 128'(x.e_sel));
    check({tag, ".err_valid"}, 128'(error_valid), 128'(x.e_err));
  endtask

  vec_t vecs[12];

  initial begin
    logic [31:0] hb [1:6];
    logic [2:0]  lvl_b [1:6];

    //            cm hdr           dat           ovr rdy val out                     lvl sel err
    vecs[0]  = v(1, 32'hAAAA0000, 32'h12345678, 0,  1,  0, 64'h0,                   1,  0,  0);
    vecs[1]  = v(0, 32'h0,        32'h0,        0,  1,  1, 64'hAAAA0000_12345678,   0,  0,  0);
    vecs[2]  = v(0, 32'h0,        32'h0,        0,  1,  0, 64'h0,                   0,  1,  0);
    vecs[3]  = v(0, 32'h0,        32'h0,        0,  1,  0, 64'h0,                   0,  0,  0);
    vecs[4]  = v(1, 32'hAAAA0001, 32'h12345678, 0,  1,  0, 64'h0,                   0,  0,  0);
    vecs[5]  = v(0, 32'hAAAA0000, 32'h12345678, 0,  1,  0, 64'h0,                   0,  0,  0);
    vecs[6]  = v(1, 32'h5555F000, 32'hCAFEF00D, 0,  1,  0, 64'h0,                   1,  0,  0);
    vecs[7]  = v(1, 32'h12340000, 32'h00000001, 0,  1,  1, 64'h5555F000_CAFEF00D,   1,  0,  0);
    vecs[8]  = v(0, 32'h0,        32'h0,        0,  1,  1, 64'h12340000_00000001,   0,  1,  0);
    vecs[9]  = v(0, 32'h0,        32'h0,        0,  0,  1, 64'h12340000_00000001,   0,  0,  0);
    vecs[10] = v(0, 32'h0,        32'h0,        0,  0,  1, 64'h12340000_00000001,   0,  0,  0);
    vecs[11] = v(0, 32'h0,        32'h0,        0,  1,  0, 64'h0,                   0,  1,  0);

    // ---------------- reset state ----------------
    resetn = 1'b1; counter_matched = 0; gpo_in = '0;
    override_en = 0; override_value = '0; gpo_out_ready = 0;
    #2 resetn = 1'b0;
    tick(); tick();
    check("rst.valid",  128'(gpo_out_valid), 128'(0));
    check("rst.out",    128'(gpo_out), 128'(0));
    check("rst.level",  128'(fifo_level), 128'(0));
    check("rst.sel",    128'(selected), 128'(0));
    check("rst.err",    128'(error_valid), 128'(0));
    check("rst.code",   128'(error_code), 128'(0));
    check("rst.data",   error_data, 128'(0));
    check("rst.count",  128'(error_count), 128'(0));
    resetn = 1'b1;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 12; i++) apply($sformatf("vec%0d", i), vecs[i]);

    // ---------------- overflow with ready low ----------------
    lvl_b = '{1, 1, 2, 3, 4, 4};
    for (int i = 1; i <= 6; i++) hb[i] = {16'hB000 + 16'(i), 16'h0000};
    for (int i = 1; i <= 6; i++)
      apply($sformatf("ovf.push%0d", i),
            v(1, hb[i], 32'h100 + 32'(i), 0, 0, (i >= 2), {hb[1], 32'h101},
              lvl_b[i], 0, (i == 6)));
    check("ovf.code", 128'(error_code), 128'(2'b01));
    check("ovf.data", error_data, mk(hb[6], 32'h106));
    apply("ovf.hold", v(0, 0, 0, 0, 0, 1, {hb[1], 32'h101}, 4, 0, 0));
    check("ovf.code_held", 128'(error_code), 128'(2'b01));
    for (int j = 2; j <= 5; j++)
      apply($sformatf("ovf.drain%0d", j),
            v(0, 0, 0, 0, 1, 1, {hb[j], 32'h100 + 32'(j)}, 3'(5 - j), 1, 0));
    apply("ovf.last", v(0, 0, 0, 0, 1, 0, 64'h0, 0, 1, 0));
    apply("ovf.idle", v(0, 0, 0, 0, 0, 0, 64'h0, 0, 0, 0));

    // ---------------- override with words queued ----------------
    apply("ovr.c1", v(1, 32'hC1000000, 32'hC1, 0, 0, 0, 64'h0, 1, 0, 0));
    apply("ovr.c2", v(1, 32'hC2000000, 32'hC2, 0, 0, 1, 64'hC1000000_000000C1, 1, 0, 0));
    apply("ovr.c3", v(1, 32'hC3000000, 32'hC3, 0, 0, 1, 64'hC1000000_000000C1, 2, 0, 0));
    apply("ovr.on", v(0, 0, 0, 1, 0, 1, OVR_VAL, 2, 0, 0));
    apply("ovr.conflict", v(1, 32'hC4000000, 32'hC4, 1, 0, 1, OVR_VAL, 2, 0, 1));
    check("ovr.code", 128'(error_code), 128'(2'b10));
    check("ovr.data", error_data, mk(32'hC4000000, 32'hC4));
    apply("ovr.accept", v(0, 0, 0, 1, 1, 1, OVR_VAL, 2, 1, 0));
    apply("ovr.off", v(0, 0, 0, 0, 0, 1, 64'hC1000000_000000C1, 2, 0, 0));
    apply("ovr.q2", v(0, 0, 0, 0, 1, 1, 64'hC2000000_000000C2, 1, 1, 0));
    apply("ovr.q3", v(0, 0, 0, 0, 1, 1, 64'hC3000000_000000C3, 0, 1, 0));
`ifndef GPO_ERROR_COUNT_EN
    check("cnt.disabled", 128'(error_count), 128'(0));
`endif

    // ---------------- async reset mid-operation ----------------
    apply("rst.d1", v(1, 32'hD1000000, 32'hD1, 0, 0, 1, 64'hC3000000_000000C3, 1, 0, 0));
    apply("rst.d2", v(1, 32'hD2000000, 32'hD2, 0, 0, 1, 64'hC3000000_000000C3, 2, 0, 0));
    apply("rst.d3", v(1, 32'hD3000000, 32'hD3, 0, 0, 1, 64'hC3000000_000000C3, 3, 0, 0));
    counter_matched = 0;
    #2 resetn = 1'b0;
    #1;
    check("arst.valid", 128'(gpo_out_valid), 128'(0));
    check("arst.out",   128'(gpo_out), 128'(0));
    check("arst.level", 128'(fifo_level), 128'(0));
    check("arst.code",  128'(error_code), 128'(0));
    check("arst.data",  error_data, 128'(0));
    check("arst.count", 128'(error_count), 128'(0));
    tick();
    resetn = 1'b1;
    apply("arst.after", v(0, 0, 0, 0, 0, 0, 64'h0, 0, 0, 0));
    check("arst.code2", 128'(error_code), 128'(0));

`ifdef GPO_ERROR_COUNT_EN
    // ---------------- error counter saturation ----------------
    counter_matched = 1; gpo_in = mk(32'hE0000000, 32'hE0);
    override_en = 0; gpo_out_ready = 0;
    for (int i = 0; i < 70005; i++) tick();
    check("cnt.sat", 128'(error_count), 128'(16'hFFFF));
    check("cnt.err_valid", 128'(error_valid), 128'(1));
    counter_matched = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
